// File: rtl/vc_output_arbiter.sv
// Round-robin output arbiter over NUM_VC buffer heads with wormhole lock and a one-entry output register.
// Optional protocol checking is enabled by defining VC_ARB_ERRCHK_EN; otherwise err_o is tied low.
module vc_output_arbiter #(
    parameter int NUM_VC  = 4,
    parameter int FLIT_W  = 34,
    parameter int VC_ID_W = 2
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [NUM_VC*FLIT_W-1:0] vc_fdata_i,
    input  logic [NUM_VC-1:0]        vc_valid_i,
    output logic [NUM_VC-1:0]        vc_ready_o,
    output logic [FLIT_W-1:0]        fdata_o,
    output logic [VC_ID_W-1:0]       vc_id_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     err_o
);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    localparam logic [1:0] FT_HEAD = 2'b00;
    localparam logic [1:0] FT_TAIL = 2'b11;

    state_t               state_q, state_d;
    logic [VC_ID_W-1:0]   owner_q, owner_d;
    logic [VC_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [VC_ID_W-1:0]   vc_id_q, vc_id_d;
    logic [FLIT_W-1:0]    fdata_q, fdata_d;
    logic                 valid_q, valid_d;

    logic [VC_ID_W-1:0]   grant;
    logic [VC_ID_W-1:0]   scan_idx;
    logic                 grant_vld;
    logic                 load;
    logic                 pop;
    logic [FLIT_W-1:0]    flit_sel;
    logic [1:0]           ftype;
    logic [FLIT_W-1:0]    vc_flit [NUM_VC];

    assign load = ~valid_q | ready_i;
    assign pop  = load & grant_vld & ~arst;

    generate
        for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
            assign vc_flit[gi]    = vc_fdata_i[gi*FLIT_W +: FLIT_W];
            assign vc_ready_o[gi] = pop && (grant == VC_ID_W'(gi));
        end
    endgenerate

    // Scan downward so the VC closest to rr_ptr is the last one written, i.e. the winner.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        scan_idx  = '0;
        if (state_q == ST_LOCKED) begin
            grant     = owner_q;
            grant_vld = vc_valid_i[owner_q];
        end else begin
            for (int i = NUM_VC - 1; i >= 0; i--) begin
                scan_idx = rr_ptr_q + VC_ID_W'(i);
                if (vc_valid_i[scan_idx]) begin
                    grant     = scan_idx;
                    grant_vld = 1'b1;
                end
            end
        end
    end

    assign flit_sel = vc_flit[grant];
    assign ftype    = flit_sel[FLIT_W-1 -: 2];

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        valid_d  = valid_q;
        fdata_d  = fdata_q;
        vc_id_d  = vc_id_q;
        if (pop) begin
            fdata_d = flit_sel;
            vc_id_d = grant;
            valid_d = 1'b1;
            if (state_q == ST_IDLE) begin
                if (ftype == FT_HEAD) begin
                    state_d = ST_LOCKED;
                    owner_d = grant;
                end else begin
                    rr_ptr_d = grant + VC_ID_W'(1);
                end
            end else if (ftype == FT_TAIL) begin
                state_d  = ST_IDLE;
                rr_ptr_d = owner_q + VC_ID_W'(1);
            end
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            valid_q  <= 1'b0;
            fdata_q  <= '0;
            vc_id_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            fdata_q  <= fdata_d;
            vc_id_q  <= vc_id_d;
        end
    end

    assign fdata_o = fdata_q;
    assign vc_id_o = vc_id_q;
    assign valid_o = valid_q;

`ifdef VC_ARB_ERRCHK_EN
    logic err_q, err_d;

    // Flag a non-head opening a packet, or a head arriving inside one.
    always_comb begin
        err_d = err_q;
        if (pop && (((state_q == ST_IDLE) && (ftype != FT_HEAD)) ||
                    ((state_q == ST_LOCKED) && (ftype == FT_HEAD)))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_vc_output_arbiter.sv
// Directed bench for vc_output_arbiter: VC buffers are modelled as queues, output transfers are
// collected and compared against hand-written expected streams.
module tb_vc_output_arbiter;

    localparam int NV = 4;
    localparam int W  = 34;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              arst;
    logic [NV*W-1:0]   vc_fdata_i;
    logic [NV-1:0]     vc_valid_i;
    logic [NV-1:0]     vc_ready_o;
    logic [W-1:0]      fdata_o;
    logic [IW-1:0]     vc_id_o;
    logic              valid_o;
    logic              ready_i;
    logic              err_o;

    vc_output_arbiter #(.NUM_VC(NV), .FLIT_W(W), .VC_ID_W(IW)) dut (
        .clk        (clk),
        .arst       (arst),
        .vc_fdata_i (vc_fdata_i),
        .vc_valid_i (vc_valid_i),
        .vc_ready_o (vc_ready_o),
        .fdata_o    (fdata_o),
        .vc_id_o    (vc_id_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W-1:0] vq [NV][$];
    logic [W-1:0] out_data [$];
    int           out_id   [$];
    int           out_cyc  [$];
    logic [W-1:0] exp_data [$];
    int           exp_id   [$];

    logic [NV-1:0] s_ready;
    logic          s_valid;
    logic          s_err;
    logic [W-1:0]  s_fdata;
    logic [IW-1:0] s_id;

`ifdef VC_ARB_ERRCHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    function automatic logic [W-1:0] mk(input logic [1:0] t, input int v, input int s);
        return {t, 16'h0, 8'(v), 8'(s)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NV; k++) begin
            vc_valid_i[k]          = (vq[k].size() != 0);
            vc_fdata_i[k*W +: W]   = (vq[k].size() != 0) ? vq[k][0] : '0;
        end
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < NV; k++) if (vq[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: sample at negedge, pop granted VCs after the edge, re-drive inputs.
    task automatic step();
        @(negedge clk);
        s_ready = vc_ready_o;
        s_valid = valid_o;
        s_err   = err_o;
        s_fdata = fdata_o;
        s_id    = vc_id_o;
        if (valid_o && ready_i) begin
            out_data.push_back(fdata_o);
            out_id.push_back(int'(vc_id_o));
            out_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        for (int k = 0; k < NV; k++) if (s_ready[k]) void'(vq[k].pop_front());
        #1;
        drive();
    endtask

    task automatic run_drain(input int maxc);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < maxc) begin
            step();
            n++;
            done = all_empty() && !s_valid && (s_ready == '0);
        end
        if (!done) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic push(input int v, input logic [1:0] t, input int s);
        vq[v].push_back(mk(t, v, s));
        exp_data.push_back(mk(t, v, s));
        exp_id.push_back(v);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, 64'(out_data.size()), 64'(exp_data.size()));
        for (int i = 0; i < exp_data.size(); i++) begin
            if (i < out_data.size()) begin
                chk($sformatf("%s_flit%0d", tag, i), 64'(out_data[i]), 64'(exp_data[i]));
                chk($sformatf("%s_id%0d", tag, i), 64'(out_id[i]), 64'(exp_id[i]));
            end
        end
        out_data.delete();
        out_id.delete();
        out_cyc.delete();
        exp_data.delete();
        exp_id.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst       = 1'b1;
        ready_i    = 1'b1;
        vc_valid_i = '0;
        vc_fdata_i = '0;
        @(posedge clk);
        #1;

        // Reset with every VC valid; these packets are the round-robin stimulus.
        for (int v = 0; v < NV; v++) begin
            push(v, 2'b00, 0);
            push(v, 2'b11, 1);
        end
        drive();
        for (int r = 0; r < 2; r++) begin
            step();
            chk("rst_valid", 64'(s_valid), 64'd0);
            chk("rst_ready", 64'(s_ready), 64'd0);
            chk("rst_err", 64'(s_err), 64'd0);
        end
        arst = 1'b0;
        step();
        chk("first_grant", 64'(s_ready), 64'b0001);

        run_drain(100);
        for (int i = 1; i < out_cyc.size(); i++)
            chk($sformatf("rr_rate%0d", i), 64'(out_cyc[i] - out_cyc[i-1]), 64'd1);
        check_stream("rr");
        chk("rr_err", 64'(s_err), 64'd0);

        // Wormhole lock: VC1 head, then VC1 empty for 3 clocks while VC2 waits.
        push(1, 2'b00, 0);
        vq[2].push_back(mk(2'b00, 2, 0));
        vq[2].push_back(mk(2'b11, 2, 1));
        drive();
        step();
        chk("lock_grant", 64'(s_ready), 64'b0010);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("lock_block%0d", i), 64'(s_ready), 64'd0);
        end
        push(1, 2'b11, 1);
        exp_data.push_back(mk(2'b00, 2, 0)); exp_id.push_back(2);
        exp_data.push_back(mk(2'b11, 2, 1)); exp_id.push_back(2);
        drive();
        run_drain(100);
        check_stream("lock");

        // Backpressure mid-packet on VC3 (rr_ptr is now 3).
        push(3, 2'b00, 0);
        push(3, 2'b01, 1);
        push(3, 2'b10, 2);
        push(3, 2'b11, 3);
        drive();
        step();
        chk("bp_grant", 64'(s_ready), 64'b1000);
        step();
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_hold%0d", i), 64'(s_fdata), 64'(mk(2'b01, 3, 1)));
            chk($sformatf("bp_id%0d", i), 64'(s_id), 64'd3);
            chk($sformatf("bp_noready%0d", i), 64'(s_ready), 64'd0);
        end
        ready_i = 1'b1;
        run_drain(100);
        check_stream("bp");

        // Wrap: VC3 tail moved rr_ptr to 0; VC0 must beat VC2.
        push(0, 2'b00, 0);
        push(0, 2'b11, 1);
        push(2, 2'b00, 0);
        push(2, 2'b11, 1);
        drive();
        step();
        chk("wrap_grant", 64'(s_ready), 64'b0001);
        run_drain(100);
        check_stream("wrap");
        chk("wrap_err", 64'(s_err), 64'd0);

        // Body flit on VC2 while IDLE: forwarded, error flagged when checking is built in.
        push(2, 2'b01, 5);
        drive();
        step();
        chk("err_grant", 64'(s_ready), 64'b0100);
        chk("err_before", 64'(s_err), 64'd0);
        step();
        chk("err_set", 64'(s_err), 64'(EXP_ERR));
        run_drain(100);
        step();
        chk("err_sticky", 64'(s_err), 64'(EXP_ERR));
        check_stream("err");

        arst = 1'b1;
        step();
        arst = 1'b0;
        step();
        chk("rst2_err", 64'(s_err), 64'd0);
        chk("rst2_valid", 64'(s_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
